// File: rtl/cmm_upsize_pack.sv
// cmm_upsize_pack: packs RATIO consecutive DWIDTH beats into one registered wide word.
// A beat marked i_last closes the word early. o_keep flags the lanes that hold data.
// Ports:
//   i_clk, rst                       clock, asynchronous active-high reset
//   i_valid, i_data, i_last, o_ready narrow beat input (valid/ready)
//   o_valid, o_data, o_keep, o_last  registered wide word output (valid/ready)
//   i_ready                          downstream accepts the wide word
module cmm_upsize_pack #(
    parameter int DWIDTH = 16,
    parameter int RATIO  = 4,
    parameter int CW     = $clog2(RATIO)
) (
    input  logic                     i_clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [DWIDTH-1:0]        i_data,
    input  logic                     i_last,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [DWIDTH*RATIO-1:0]  o_data,
    output logic [RATIO-1:0]         o_keep,
    output logic                     o_last,
    input  logic                     i_ready
);

    localparam int unsigned OW = DWIDTH * RATIO;
    localparam int unsigned AW = DWIDTH * (RATIO - 1);

    logic [CW-1:0]    cnt;
    logic [AW-1:0]    acc_data;
    logic [RATIO-2:0] acc_keep;

    logic             acc_en;
    logic             close;
    logic [OW-1:0]    acc_full;
    logic [RATIO-1:0] keep_full;
    logic [OW-1:0]    word_data;
    logic [RATIO-1:0] word_keep;

    // Accept whenever the output register is empty or draining this cycle.
    assign o_ready = !o_valid || i_ready;
    assign acc_en  = i_valid && o_ready;
    assign close   = acc_en && ((cnt == CW'(RATIO - 1)) || i_last);

    // Pad the accumulator to full width so every lane index stays in range.
    assign acc_full  = {DWIDTH'(0), acc_data};
    assign keep_full = {1'b0, acc_keep};

    // Word formed on a close: held lanes below cnt, the new beat at cnt, zeros above.
    always_comb begin
        word_data = '0;
        word_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) == cnt) begin
                word_data[k*DWIDTH +: DWIDTH] = i_data;
                word_keep[k]                  = 1'b1;
            end else if ((CW'(k) < cnt) && keep_full[k]) begin
                word_data[k*DWIDTH +: DWIDTH] = acc_full[k*DWIDTH +: DWIDTH];
                word_keep[k]                  = 1'b1;
            end
        end
    end

    // Accumulator, lane counter and output register.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_keep   <= '0;
            o_last   <= 1'b0;
        end else if (close) begin
            // A close in the same cycle as a drain simply replaces the word.
            o_data   <= word_data;
            o_keep   <= word_keep;
            o_last   <= i_last;
            o_valid  <= 1'b1;
            cnt      <= '0;
            acc_keep <= '0;
        end else begin
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (acc_en) begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (CW'(k) == cnt) begin
                        acc_data[k*DWIDTH +: DWIDTH] <= i_data;
                        acc_keep[k]                  <= 1'b1;
                    end
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmm_upsize_pack.sv
// Directed bench for cmm_upsize_pack with DWIDTH=16, RATIO=4.
module tb_cmm_upsize_pack;

    localparam int DW = 16;
    localparam int RT = 4;
    localparam int OW = DW * RT;

    logic          i_clk;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          i_last;
    logic          o_ready;
    logic          o_valid;
    logic [OW-1:0] o_data;
    logic [RT-1:0] o_keep;
    logic          o_last;
    logic          i_ready;

    int checks = 0;
    int errors = 0;

    cmm_upsize_pack #(.DWIDTH(DW), .RATIO(RT)) dut (
        .i_clk   (i_clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat for a single clock, then sample 1 time unit after the edge.
    task automatic beat(input logic [DW-1:0] d, input logic l);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    logic [DW-1:0] rnd [64];
    logic [OW-1:0] exp_word;
    logic [OW-1:0] held;
    int            words;
    int            ready_drops;

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data",  64'(o_data),  64'd0);
        check("rst_o_keep",  64'(o_keep),  64'd0);
        check("rst_o_last",  64'(o_last),  64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        rst = 1'b0;

        // Full word from four consecutive beats.
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b0);
        beat(16'h3333, 1'b0);
        check("full_not_yet", 64'(o_valid), 64'd0);
        beat(16'h4444, 1'b0);
        check("full_valid", 64'(o_valid), 64'd1);
        check("full_data",  64'(o_data),  64'h4444_3333_2222_1111);
        check("full_keep",  64'(o_keep),  64'hf);
        check("full_last",  64'(o_last),  64'd0);

        // Early close on lane 1.
        beat(16'hAAAA, 1'b0);
        check("drain_valid", 64'(o_valid), 64'd0);
        beat(16'hBBBB, 1'b1);
        check("part_valid", 64'(o_valid), 64'd1);
        check("part_data",  64'(o_data),  64'h0000_0000_BBBB_AAAA);
        check("part_keep",  64'(o_keep),  64'h3);
        check("part_last",  64'(o_last),  64'd1);

        // Single-beat packet must land in lane 0.
        beat(16'h5A5A, 1'b1);
        check("single_data", 64'(o_data), 64'h0000_0000_0000_5A5A);
        check("single_keep", 64'(o_keep), 64'h1);
        check("single_last", 64'(o_last), 64'd1);

        // Stall with a closing beat offered, then release.
        beat(16'h0001, 1'b0);
        beat(16'h0002, 1'b0);
        beat(16'h0003, 1'b0);
        beat(16'h0004, 1'b0);
        held = 64'h0004_0003_0002_0001;
        check("stall_word", 64'(o_data), held);
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_valid = 1'b1;
            i_data  = 16'h9999;
            i_last  = 1'b1;
            #1;
            check("stall_o_ready", 64'(o_ready), 64'd0);
            @(posedge i_clk);
            #1;
            check("stall_o_valid", 64'(o_valid), 64'd1);
            check("stall_o_data",  64'(o_data),  held);
            check("stall_o_keep",  64'(o_keep),  64'hf);
        end
        i_ready = 1'b1;
        #1;
        check("release_o_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        check("b2b_valid", 64'(o_valid), 64'd1);
        check("b2b_data",  64'(o_data),  64'h0000_0000_0000_9999);
        check("b2b_keep",  64'(o_keep),  64'h1);
        check("b2b_last",  64'(o_last),  64'd1);
        @(posedge i_clk);
        #1;
        check("b2b_drained", 64'(o_valid), 64'd0);

        // Streaming: 64 random beats, one per cycle.
        for (int i = 0; i < 64; i++) rnd[i] = DW'($urandom);
        words       = 0;
        ready_drops = 0;
        for (int i = 0; i < 64; i++) begin
            i_valid = 1'b1;
            i_data  = rnd[i];
            i_last  = 1'b0;
            #1;
            if (!o_ready) ready_drops++;
            @(posedge i_clk);
            #1;
            if ((i % 4) == 3) begin
                exp_word = {rnd[i], rnd[i-1], rnd[i-2], rnd[i-3]};
                words++;
                check("stream_valid", 64'(o_valid), 64'd1);
                check("stream_data",  64'(o_data),  exp_word);
                check("stream_keep",  64'(o_keep),  64'hf);
            end else if (i > 0) begin
                check("stream_gap", 64'(o_valid), 64'd0);
            end
        end
        i_valid = 1'b0;
        check("stream_words", 64'(words), 64'd16);
        check("stream_ready_drops", 64'(ready_drops), 64'd0);

        // Reset mid-packet discards the partial word.
        beat(16'h7777, 1'b0);
        beat(16'h8888, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        check("midrst_o_data",  64'(o_data),  64'd0);
        check("midrst_o_keep",  64'(o_keep),  64'd0);
        check("midrst_o_last",  64'(o_last),  64'd0);
        check("midrst_o_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1;
        rst = 1'b0;
        beat(16'hC001, 1'b0);
        beat(16'hC002, 1'b0);
        beat(16'hC003, 1'b0);
        check("postrst_not_yet", 64'(o_valid), 64'd0);
        beat(16'hC004, 1'b0);
        check("postrst_valid", 64'(o_valid), 64'd1);
        check("postrst_data",  64'(o_data),  64'hC004_C003_C002_C001);
        check("postrst_keep",  64'(o_keep),  64'hf);
        check("postrst_last",  64'(o_last),  64'd0);

        @(posedge i_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
